// File: rtl/xor_serial_sequencer.sv
// Bit-serial XOR engine shared by two requesters through a single 1-bit datapath.
// Round-robin arbitration; operands shift LSB-first and result/parity are returned per op.
module xor_serial_sequencer #(
  parameter int          WIDTH       = 8,
  parameter int unsigned BubblesMask = 0
) (
  input  logic             GlobalClock,
  input  logic             Reset_n,
  input  logic             Req_A,
  input  logic [WIDTH-1:0] Operand_1_A,
  input  logic [WIDTH-1:0] Operand_2_A,
  output logic             Ack_A,
  input  logic             Req_B,
  input  logic [WIDTH-1:0] Operand_1_B,
  input  logic [WIDTH-1:0] Operand_2_B,
  output logic             Ack_B,
  output logic             Busy,
  output logic [WIDTH-1:0] Result,
  output logic             Result_Parity,
  output logic             Result_Valid,
  output logic             Result_Owner
);

  localparam int         CW   = $clog2(WIDTH);
  localparam logic [1:0] MASK = 2'(BubblesMask);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             ptr;      // 0: A has priority on a tie, 1: B
  logic             owner;
  logic             par;
  logic [WIDTH-1:0] op1, op2, res;
  logic             r;
  logic             grant_b;

  assign r       = (op1[0] ^ MASK[0]) ^ (op2[0] ^ MASK[1]);
  assign grant_b = Req_B & (~Req_A | ptr);
  assign Busy    = (state != IDLE);

  always_ff @(posedge GlobalClock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      par           <= 1'b0;
      op1           <= '0;
      op2           <= '0;
      res           <= '0;
      Ack_A         <= 1'b0;
      Ack_B         <= 1'b0;
      Result        <= '0;
      Result_Parity <= 1'b0;
      Result_Valid  <= 1'b0;
      Result_Owner  <= 1'b0;
    end else begin
      Ack_A        <= 1'b0;
      Ack_B        <= 1'b0;
      Result_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_A | Req_B) begin
            op1   <= grant_b ? Operand_1_B : Operand_1_A;
            op2   <= grant_b ? Operand_2_B : Operand_2_A;
            owner <= grant_b;
            Ack_A <= ~grant_b;
            Ack_B <= grant_b;
            // priority moves to the loser only when there was contention
            if (Req_A & Req_B) ptr <= ~grant_b;
            cnt   <= '0;
            res   <= '0;
            par   <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          op1 <= op1 >> 1;
          op2 <= op2 >> 1;
          res <= {r, res[WIDTH-1:1]};
          par <= par ^ r;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          Result        <= res;
          Result_Parity <= par;
          Result_Owner  <= owner;
          Result_Valid  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_serial_sequencer.sv
// Directed + randomized bench for xor_serial_sequencer; three instances cover bubble masks 0, 1 and 3.
module tb_xor_serial_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a, req_b;
  logic [W-1:0] a1, a2, b1, b2;

  logic         ack_a [3];
  logic         ack_b [3];
  logic         busy  [3];
  logic [W-1:0] result[3];
  logic         rpar  [3];
  logic         rval  [3];
  logic         rown  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit prio;                 // model: who wins the next tie (0 = A)
  logic [W-1:0] prev_res;   // model: last completed result of instance 0

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xor_serial_sequencer #(.WIDTH(W), .BubblesMask(0)) u_m0 (
    .GlobalClock(clk), .Reset_n(rst_n),
    .Req_A(req_a), .Operand_1_A(a1), .Operand_2_A(a2), .Ack_A(ack_a[0]),
    .Req_B(req_b), .Operand_1_B(b1), .Operand_2_B(b2), .Ack_B(ack_b[0]),
    .Busy(busy[0]), .Result(result[0]), .Result_Parity(rpar[0]),
    .Result_Valid(rval[0]), .Result_Owner(rown[0]));

  xor_serial_sequencer #(.WIDTH(W), .BubblesMask(1)) u_m1 (
    .GlobalClock(clk), .Reset_n(rst_n),
    .Req_A(req_a), .Operand_1_A(a1), .Operand_2_A(a2), .Ack_A(ack_a[1]),
    .Req_B(req_b), .Operand_1_B(b1), .Operand_2_B(b2), .Ack_B(ack_b[1]),
    .Busy(busy[1]), .Result(result[1]), .Result_Parity(rpar[1]),
    .Result_Valid(rval[1]), .Result_Owner(rown[1]));

  xor_serial_sequencer #(.WIDTH(W), .BubblesMask(3)) u_m3 (
    .GlobalClock(clk), .Reset_n(rst_n),
    .Req_A(req_a), .Operand_1_A(a1), .Operand_2_A(a2), .Ack_A(ack_a[2]),
    .Req_B(req_b), .Operand_1_B(b1), .Operand_2_B(b2), .Ack_B(ack_b[2]),
    .Busy(busy[2]), .Result(result[2]), .Result_Parity(rpar[2]),
    .Result_Valid(rval[2]), .Result_Owner(rown[2]));

  function automatic logic [1:0] mask_of(input int i);
    return (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b11;
  endfunction

  // Reference: bitwise XOR of the (optionally inverted) operands.
  function automatic logic [W-1:0] ref_xor(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] m);
    return (x ^ {W{m[0]}}) ^ (y ^ {W{m[1]}});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_ack_a"}, 32'(ack_a[i]), 32'd0);
      check({tag, "_ack_b"}, 32'(ack_b[i]), 32'd0);
      check({tag, "_busy"},  32'(busy[i]),  32'd0);
      check({tag, "_res"},   32'(result[i]), 32'd0);
      check({tag, "_par"},   32'(rpar[i]),  32'd0);
      check({tag, "_val"},   32'(rval[i]),  32'd0);
      check({tag, "_own"},   32'(rown[i]),  32'd0);
    end
  endtask

  // Runs one operation from the capture edge to the Valid cycle. Reqs must already be set.
  task automatic serve(input bit hold, input int raise_b_at, output bit own, output int vt);
    bit           e_own;
    logic [W-1:0] c1, c2, e_r;
    int           k;
    bit           seen;
    e_own = (req_a && req_b) ? prio : req_b;
    c1 = e_own ? b1 : a1;
    c2 = e_own ? b2 : a2;
    if (req_a && req_b) prio = !e_own;
    step();
    for (int i = 0; i < 3; i++) begin
      check("ack_a", 32'(ack_a[i]), 32'(!e_own));
      check("ack_b", 32'(ack_b[i]), 32'(e_own));
      check("busy",  32'(busy[i]),  32'd1);
    end
    check("hold_res", 32'(result[0]), 32'(prev_res));
    if (!hold) begin
      if (e_own) req_b = 1'b0; else req_a = 1'b0;
    end
    // owner may change operands right after Ack; the captured values must be used
    if (e_own) begin b1 = W'($urandom); b2 = W'($urandom); end
    else       begin a1 = W'($urandom); a2 = W'($urandom); end
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      step();
      k++;
      seen = rval[0];
      if (!seen) begin
        check("no_ack", 32'(ack_a[0] | ack_b[0]), 32'd0);
        check("no_glitch", 32'(result[0]), 32'(prev_res));
      end
      if (k == raise_b_at) begin
        req_b = 1'b1; b1 = W'($urandom); b2 = W'($urandom);
      end
    end
    check("latency", 32'(k), 32'd9);
    for (int i = 0; i < 3; i++) begin
      e_r = ref_xor(c1, c2, mask_of(i));
      check("result", 32'(result[i]), 32'(e_r));
      check("parity", 32'(rpar[i]),   32'(^e_r));
      check("owner",  32'(rown[i]),   32'(e_own));
      check("valid",  32'(rval[i]),   32'd1);
    end
    prev_res = ref_xor(c1, c2, 2'b00);
    own = e_own;
    vt  = cyc;
  endtask

  initial begin
    bit own, prev_own;
    int t1, t2;
    logic [2:0] pat;

    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    a1 = '0; a2 = '0; b1 = '0; b2 = '0;
    prio = 1'b0; prev_res = '0;
    #3;
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // both request from reset: A first, then B, valid pulses 10 cycles apart
    req_a = 1'b1; a1 = 8'hFF; a2 = 8'h0F;
    req_b = 1'b1; b1 = 8'h01; b2 = 8'h00;
    serve(1'b0, 0, own, t1);
    check("tie_first_owner", 32'(own), 32'd0);
    check("tie_a_res", 32'(result[0]), 32'hF0);
    check("tie_a_par", 32'(rpar[0]), 32'd0);
    serve(1'b0, 0, own, t2);
    check("tie_second_owner", 32'(own), 32'd1);
    check("tie_b_res", 32'(result[0]), 32'h01);
    check("tie_b_par", 32'(rpar[0]), 32'd1);
    check("valid_spacing", 32'(t2 - t1), 32'd10);

    // A alone with the reference vector, plus the masked instances
    step();
    req_a = 1'b1; a1 = 8'hA5; a2 = 8'h3C;
    serve(1'b0, 0, own, t1);
    check("vec_a5_res", 32'(result[0]), 32'h99);
    check("vec_a5_par", 32'(rpar[0]), 32'd0);
    req_a = 1'b1; a1 = 8'h00; a2 = 8'h00;
    serve(1'b0, 0, own, t1);
    check("mask01_res", 32'(result[1]), 32'hFF);
    check("mask01_par", 32'(rpar[1]), 32'd0);
    req_a = 1'b1; a1 = 8'h12; a2 = 8'h34;
    serve(1'b0, 0, own, t1);
    check("mask11_res", 32'(result[2]), 32'h26);
    check("mask11_par", 32'(rpar[2]), 32'd1);

    // B rises mid-operation: no Ack_B until A completes, then B granted
    req_a = 1'b1; a1 = W'($urandom); a2 = W'($urandom);
    serve(1'b0, 3, own, t1);
    check("late_b_first", 32'(own), 32'd0);
    serve(1'b0, 0, own, t2);
    check("late_b_owner", 32'(own), 32'd1);
    check("late_b_spacing", 32'(t2 - t1), 32'd10);

    // continuous requests alternate owners
    req_a = 1'b1; req_b = 1'b1;
    serve(1'b1, 0, prev_own, t1);
    for (int n = 0; n < 4; n++) begin
      serve(1'b1, 0, own, t1);
      check("alternate", 32'(own), 32'(!prev_own));
      prev_own = own;
    end

    // random request patterns and operands
    for (int n = 0; n < 16; n++) begin
      pat = 3'($urandom_range(1, 3));
      req_a = pat[0]; req_b = pat[1];
      a1 = W'($urandom); a2 = W'($urandom);
      b1 = W'($urandom); b2 = W'($urandom);
      serve(1'b0, 0, own, t1);
    end

    // reset in SHIFT cycle 4 discards the operation
    req_b = 1'b0;
    req_a = 1'b1; a1 = W'($urandom); a2 = W'($urandom);
    step();
    check("rst_ack", 32'(ack_a[0]), 32'd1);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    step();
    check("midrst_noval", 32'(rval[0]), 32'd0);
    step();
    check("midrst_noval2", 32'(rval[0]), 32'd0);
    rst_n = 1'b1;
    prio = 1'b0;
    prev_res = '0;
    serve(1'b0, 0, own, t1);
    check("post_rst_owner", 32'(own), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
